hazard_ctl: RTL and testbench

Issue/stall controller for the decode stage of the integer/predicate/FP pipeline. It keeps a per-register countdown scoreboard for the three register files and holds decode whenever a source or destination register is still pending. Pending writes come from loads and the non-pipelined FPU. It also arbitrates the single FPU and freezes issue during memory wait. It sits between decode and EX, alongside the operand-forwarding unit, and covers only hazards that forwarding cannot resolve.

---
 rtl/hazard_pkg.sv | 30 +++
 rtl/hazard_ctl_sb_bank.sv | 49 ++++
 rtl/hazard_ctl.sv | 124 ++++++++++++
 tb/tb_hazard_ctl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and latency defaults for the decode-stage hazard controller.
package hazard_pkg;

    localparam int NREG     = 16;
    localparam int IDX_W    = 4;
    localparam int CNT_W    = 3;
    localparam int LOAD_LAT = 1;
    localparam int FPU_LAT  = 4;

    typedef enum logic [1:0] {
        RF_NONE = 2'b00,
        RF_INT  = 2'b01,
        RF_PRED = 2'b10,
        RF_FP   = 2'b11
    } rf_e;

    typedef enum logic [1:0] {
        CL_ALU  = 2'b00,
        CL_LOAD = 2'b01,
        CL_FPU  = 2'b10,
        CL_NOWB = 2'b11
    } class_e;

    typedef enum logic [1:0] {
        ST_RUN = 2'b00,
        ST_HAZ = 2'b01,
        ST_FRZ = 2'b10
    } state_e;

endpackage

// File: rtl/hazard_ctl_sb_bank.sv
// One register file's countdown scoreboard: a counter per register, a set port,
// a shared decrement enable, two read ports and the full busy vector.
module sb_bank
    import hazard_pkg::*;
#(
    parameter int N_REG   = NREG,
    parameter int IDX_WID = IDX_W,
    parameter int CNT_WID = CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_set_en,
    input  logic [IDX_WID-1:0] i_set_idx,
    input  logic [CNT_WID-1:0] i_set_val,
    input  logic               i_dec_en,
    input  logic [IDX_WID-1:0] i_rd_idx1,
    input  logic [IDX_WID-1:0] i_rd_idx2,
    output logic               o_rd_busy1,
    output logic               o_rd_busy2,
    output logic [N_REG-1:0]   o_busy
);

    logic [CNT_WID-1:0] r_cnt [N_REG];

    // The issue logic never sets a counter that is still nonzero, so set
    // taking precedence over decrement only matters for a counter already at 0.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REG; i++) begin
            if (rst) begin
                r_cnt[i] <= '0;
            end else if (i_set_en && (i_set_idx == IDX_WID'(i))) begin
                r_cnt[i] <= i_set_val;
            end else if (i_dec_en && (r_cnt[i] != '0)) begin
                r_cnt[i] <= r_cnt[i] - 1'b1;
            end
        end
    end

    always_comb begin
        o_busy = '0;
        for (int i = 0; i < N_REG; i++) begin
            o_busy[i] = (r_cnt[i] != '0);
        end
    end

    assign o_rd_busy1 = o_busy[i_rd_idx1];
    assign o_rd_busy2 = o_busy[i_rd_idx2];

endmodule

// File: rtl/hazard_ctl.sv
// Decode-stage issue/stall controller: per-file countdown scoreboards, single
// FPU arbitration and freeze during memory wait.
module hazard_ctl
    import hazard_pkg::*;
#(
    parameter int LD_LAT = LOAD_LAT,
    parameter int FP_LAT = FPU_LAT,
    parameter int CW     = CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [3:0]  id_src1,
    input  logic [3:0]  id_src2,
    input  logic [1:0]  id_src1_rf,
    input  logic [1:0]  id_src2_rf,
    input  logic [3:0]  id_dst,
    input  logic [1:0]  id_dst_rf,
    input  logic [1:0]  id_class,
    input  logic        mem_wait,
    input  logic        flush,
    output logic        issue,
    output logic        id_stall,
    output logic        fpu_start,
    output logic [15:0] busy_int,
    output logic [15:0] busy_pred,
    output logic [15:0] busy_fp,
    output logic [1:0]  state
);

    logic [CW-1:0] r_fpu_cnt;
    state_e        r_state;

    logic          w_s1_int, w_s2_int, w_s1_pred, w_s2_pred, w_s1_fp, w_s2_fp;
    logic          w_src1_busy, w_src2_busy, w_dst_busy, w_struct;
    logic          w_hazard, w_set, w_dec_en, w_is_fpu;
    logic [CW-1:0] w_set_val;

    // Handshake: decode offers an instruction with id_valid; it is accepted
    // (issue) in the same cycle only when no freeze, flush or hazard holds it.
    // id_stall tells decode to keep the instruction; a flushed one just vanishes.
    always_comb begin
        w_src1_busy = 1'b0;
        case (rf_e'(id_src1_rf))
            RF_INT:  w_src1_busy = w_s1_int;
            RF_PRED: w_src1_busy = w_s1_pred;
            RF_FP:   w_src1_busy = w_s1_fp;
            default: w_src1_busy = 1'b0;
        endcase
        w_src2_busy = 1'b0;
        case (rf_e'(id_src2_rf))
            RF_INT:  w_src2_busy = w_s2_int;
            RF_PRED: w_src2_busy = w_s2_pred;
            RF_FP:   w_src2_busy = w_s2_fp;
            default: w_src2_busy = 1'b0;
        endcase
        w_dst_busy = 1'b0;
        case (rf_e'(id_dst_rf))
            RF_INT:  w_dst_busy = busy_int[id_dst];
            RF_PRED: w_dst_busy = busy_pred[id_dst];
            RF_FP:   w_dst_busy = busy_fp[id_dst];
            default: w_dst_busy = 1'b0;
        endcase
    end

    assign w_is_fpu  = (id_class == CL_FPU);
    assign w_struct  = w_is_fpu && (r_fpu_cnt != '0);
    assign w_hazard  = id_valid && (w_src1_busy || w_src2_busy || w_dst_busy || w_struct);

    assign issue     = !rst && id_valid && !mem_wait && !flush && !w_hazard;
    assign id_stall  = !rst && id_valid && !flush && (mem_wait || w_hazard);
    assign fpu_start = issue && w_is_fpu;

    assign w_set     = issue && ((id_class == CL_LOAD) || w_is_fpu) && (id_dst_rf != RF_NONE);
    assign w_set_val = w_is_fpu ? CW'(FP_LAT) : CW'(LD_LAT);
    assign w_dec_en  = !mem_wait;

    sb_bank #(.CNT_WID(CW)) u_sb_int (
        .clk(clk), .rst(rst),
        .i_set_en(w_set && (id_dst_rf == RF_INT)), .i_set_idx(id_dst), .i_set_val(w_set_val),
        .i_dec_en(w_dec_en), .i_rd_idx1(id_src1), .i_rd_idx2(id_src2),
        .o_rd_busy1(w_s1_int), .o_rd_busy2(w_s2_int), .o_busy(busy_int)
    );

    sb_bank #(.CNT_WID(CW)) u_sb_pred (
        .clk(clk), .rst(rst),
        .i_set_en(w_set && (id_dst_rf == RF_PRED)), .i_set_idx(id_dst), .i_set_val(w_set_val),
        .i_dec_en(w_dec_en), .i_rd_idx1(id_src1), .i_rd_idx2(id_src2),
        .o_rd_busy1(w_s1_pred), .o_rd_busy2(w_s2_pred), .o_busy(busy_pred)
    );

    sb_bank #(.CNT_WID(CW)) u_sb_fp (
        .clk(clk), .rst(rst),
        .i_set_en(w_set && (id_dst_rf == RF_FP)), .i_set_idx(id_dst), .i_set_val(w_set_val),
        .i_dec_en(w_dec_en), .i_rd_idx1(id_src1), .i_rd_idx2(id_src2),
        .o_rd_busy1(w_s1_fp), .o_rd_busy2(w_s2_fp), .o_busy(busy_fp)
    );

    // FPU occupancy is tracked even for FPU ops whose result is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fpu_cnt <= '0;
        end else if (fpu_start) begin
            r_fpu_cnt <= CW'(FP_LAT);
        end else if (w_dec_en && (r_fpu_cnt != '0)) begin
            r_fpu_cnt <= r_fpu_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else if (mem_wait) begin
            r_state <= ST_FRZ;
        end else if (w_hazard && !flush) begin
            r_state <= ST_HAZ;
        end else begin
            r_state <= ST_RUN;
        end
    end

    assign state = r_state;

endmodule

// File: tb/tb_hazard_ctl.sv
// Randomized and directed bench for hazard_ctl against a ready-time reference model.
module tb_hazard_ctl;

    localparam int LD_LAT = 1;
    localparam int FP_LAT = 4;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_src1, id_src2, id_dst;
    logic [1:0]  id_src1_rf, id_src2_rf, id_dst_rf, id_class;
    logic        mem_wait, flush;
    logic        issue, id_stall, fpu_start;
    logic [15:0] busy_int, busy_pred, busy_fp;
    logic [1:0]  state;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: each register records the "active time" (count of
    // non-frozen cycles) at which its result becomes available.
    int t_act;
    int ready_at [4][16];
    int fpu_ready;
    int m_state;

    logic obs_issue, obs_stall;

    hazard_ctl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_rf(id_src1_rf), .id_src2_rf(id_src2_rf),
        .id_dst(id_dst), .id_dst_rf(id_dst_rf), .id_class(id_class),
        .mem_wait(mem_wait), .flush(flush),
        .issue(issue), .id_stall(id_stall), .fpu_start(fpu_start),
        .busy_int(busy_int), .busy_pred(busy_pred), .busy_fp(busy_fp),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit pend(input int rf, input int idx);
        return (rf != 0) && (t_act < ready_at[rf][idx]);
    endfunction

    function automatic logic [15:0] busy_vec(input int rf);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) v[i] = pend(rf, i);
        return v;
    endfunction

    task automatic model_reset();
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < 16; i++) ready_at[f][i] = 0;
        fpu_ready = 0;
        m_state   = 0;
    endtask

    // One clock cycle: apply inputs, check outputs mid-cycle, advance the model.
    task automatic drive(input logic v, input int s1, input int s1rf, input int s2, input int s2rf,
                         input int d, input int drf, input int cls,
                         input logic mw, input logic fl, input logic r);
        bit haz, e_issue, e_stall, e_fpu;
        id_valid   = v;
        id_src1    = 4'(s1);
        id_src1_rf = 2'(s1rf);
        id_src2    = 4'(s2);
        id_src2_rf = 2'(s2rf);
        id_dst     = 4'(d);
        id_dst_rf  = 2'(drf);
        id_class   = 2'(cls);
        mem_wait   = mw;
        flush      = fl;
        rst        = r;
        @(negedge clk);
        haz = v && (pend(s1rf, s1) || pend(s2rf, s2) || pend(drf, d) ||
                    (cls == 2 && t_act < fpu_ready));
        e_issue = !r && v && !mw && !fl && !haz;
        e_stall = !r && v && !fl && (mw || haz);
        e_fpu   = e_issue && (cls == 2);
        check_eq("issue",     32'(issue),     32'(e_issue));
        check_eq("id_stall",  32'(id_stall),  32'(e_stall));
        check_eq("fpu_start", 32'(fpu_start), 32'(e_fpu));
        check_eq("busy_int",  32'(busy_int),  32'(busy_vec(1)));
        check_eq("busy_pred", 32'(busy_pred), 32'(busy_vec(2)));
        check_eq("busy_fp",   32'(busy_fp),   32'(busy_vec(3)));
        check_eq("state",     32'(state),     32'(m_state));
        obs_issue = issue;
        obs_stall = id_stall;
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else begin
            if (e_issue && (cls == 1 || cls == 2) && drf != 0)
                ready_at[drf][d] = t_act + 1 + ((cls == 2) ? FP_LAT : LD_LAT);
            if (e_fpu) fpu_ready = t_act + 1 + FP_LAT;
            if (!mw) t_act++;
            m_state = mw ? 2 : ((haz && !fl) ? 1 : 0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    // Re-present one instruction until it issues; report how many cycles it stalled.
    task automatic count_stalls(input string tag, input int s1, input int s1rf, input int s2, input int s2rf,
                                input int d, input int drf, input int cls, input int exp_n);
        int n;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, s1, s1rf, s2, s2rf, d, drf, cls, 1'b0, 1'b0, 1'b0);
            if (obs_issue) break;
            n++;
        end
        check_eq(tag, 32'(n), 32'(exp_n));
    endtask

    initial begin
        t_act = 0;
        model_reset();
        id_valid = 0; id_src1 = 0; id_src2 = 0; id_src1_rf = 0; id_src2_rf = 0;
        id_dst = 0; id_dst_rf = 0; id_class = 0; mem_wait = 0; flush = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Load r3 then ALU consumer of r3.
        drive(1'b1, 0, 0, 0, 0, 3, 1, 1, 1'b0, 1'b0, 1'b0);
        count_stalls("load_use_stalls", 3, 1, 0, 0, 4, 1, 0, LD_LAT);
        idle(6);

        // FPU op to f5 then another FPU op: structural stall.
        drive(1'b1, 0, 0, 0, 0, 5, 3, 2, 1'b0, 1'b0, 1'b0);
        count_stalls("fpu_struct_stalls", 2, 3, 0, 0, 6, 3, 2, FP_LAT);
        idle(6);

        // Load r7, freeze 3 cycles, then consumer.
        drive(1'b1, 0, 0, 0, 0, 7, 1, 1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        check_eq("frz_busy_r7", 32'(busy_int[7]), 32'd1);
        count_stalls("frz_use_stalls", 7, 1, 0, 0, 8, 1, 0, 1);
        idle(6);

        // FPU writing p2, then a load to p2: WAW stall.
        drive(1'b1, 0, 0, 0, 0, 2, 2, 2, 1'b0, 1'b0, 1'b0);
        count_stalls("waw_stalls", 0, 0, 0, 0, 2, 2, 1, FP_LAT);
        idle(6);

        // Hazarded instruction under flush is dropped silently.
        drive(1'b1, 0, 0, 0, 0, 5, 3, 2, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 5, 3, 0, 0, 9, 1, 1, 1'b0, 1'b1, 1'b0);
        check_eq("flush_stall", 32'(obs_stall), 32'd0);
        check_eq("flush_noset", 32'(busy_int[9]), 32'd0);
        idle(6);

        // Reset with an FPU result pending, then a dependent FPU op.
        drive(1'b1, 0, 0, 0, 0, 1, 3, 2, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        count_stalls("rst_drop_stalls", 1, 3, 0, 0, 2, 3, 2, 0);
        idle(6);

        for (int c = 0; c < 2000; c++) begin
            drive(($urandom_range(0, 3) != 0),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 79) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
